// File: rtl/pps_pkg.sv
// Purpose: shared selection codes, FSM encoding and selection stepping for PPS discipline.
// Latency: n/a (package only).
// Backpressure: n/a.
package pps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_NOM  = 2'd0;
    localparam logic [1:0] SEL_SLOW = 2'd1;
    localparam logic [1:0] SEL_MID  = 2'd2;
    localparam logic [1:0] SEL_FAST = 2'd3;

    // Manual stepping order nominal -> slow -> mid -> fast -> nominal.
    function automatic logic [1:0] step_sel(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/pps_in_sync.sv
// Purpose: 2-flop synchroniser for a raw pin plus a one-cycle rising-edge pulse.
// Latency: pulse is sampled by the consumer 3 clock edges after the pin transition.
// Backpressure: none; free-running.
module pps_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Shift the pin through the synchroniser and one extra stage for edge detect.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pps_discipline_ctrl.sv
// Purpose: measures local-PPS vs pps_in phase each second and steers the timer increment select.
// Latency: a_incr_sel/phase_err/err_valid update 1 cycle after the local_pps that ends a second.
// Backpressure: none; one evaluation per local_pps.
module pps_discipline_ctrl
    import pps_pkg::*;
#(
    parameter int PERIOD_CYCLES = 120000000,
    parameter int CNT_W         = 27,
    parameter int DEADBAND      = 12,
    parameter int LOCK_COUNT    = 4,
    parameter int MAX_MISS      = 3
) (
    input  logic             clk_pps,
    input  logic             reset_pps_n,
    input  logic             pps_in,
    input  logic             local_pps,
    input  logic             button2_pulse,
    input  logic             auto_en,
    output logic [1:0]       a_incr_sel,
    output logic             locked,
    output logic [CNT_W:0]   phase_err,
    output logic             err_valid
);

    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam logic [CNT_W-1:0]        HALF     = CNT_W'(PERIOD_CYCLES / 2);
    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic signed [CNT_W:0]   PERIOD_S = (CNT_W+1)'(PERIOD_CYCLES);
    localparam logic signed [CNT_W:0]   DB_POS   = (CNT_W+1)'(DEADBAND);
    localparam logic signed [CNT_W:0]   DB_NEG   = -DB_POS;
    localparam logic [LW-1:0]           LOCK_MAX = LW'(LOCK_COUNT);
    localparam logic [MW-1:0]           MISS_MAX = MW'(MAX_MISS);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cap_q, cap_d;
    logic                    seen_q, seen_d;
    logic [MW-1:0]           miss_q, miss_d;
    logic [LW-1:0]           lock_cnt_q, lock_cnt_d;
    logic                    locked_q, locked_d;
    logic [1:0]              sel_q, sel_d;
    logic signed [CNT_W:0]   err_q, err_d;
    logic                    err_vld_q, err_vld_d;
    logic                    manual_q, manual_d;
    logic                    auto_en_q, auto_en_d;

    logic                    pps_edge;
    logic                    auto_active;
    logic                    in_band;
    logic signed [CNT_W:0]   cap_s;
    logic signed [CNT_W:0]   eval_err;

    pps_in_sync u_sync (
        .clk   (clk_pps),
        .rst_n (reset_pps_n),
        .din   (pps_in),
        .rise  (pps_edge)
    );

    // Fold the captured count into a signed error around the nominal second.
    always_comb begin
        cap_s    = $signed({1'b0, cap_q});
        eval_err = (cap_q < HALF) ? cap_s : (cap_s - PERIOD_S);
        in_band  = (eval_err <= DB_POS) && (eval_err >= DB_NEG);
    end

    assign auto_active = auto_en & ~manual_q;

    // Next-state: measurement FSM, evaluation at the second boundary, manual override last.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        seen_d     = seen_q;
        miss_d     = miss_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        sel_d      = sel_q;
        err_d      = err_q;
        err_vld_d  = 1'b0;
        manual_d   = manual_q;
        auto_en_d  = auto_en;

        case (state_q)
            ST_IDLE: begin
                if (local_pps) begin
                    // cnt_q holds "cycles since local_pps"; the pulse cycle itself is count 0.
                    cnt_d   = CNT_W'(1);
                    seen_d  = 1'b0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE, ST_EVAL: begin
                state_d = ST_MEASURE;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (pps_edge && !seen_q) begin
                    seen_d = 1'b1;
                    cap_d  = cnt_q;
                end
                if (local_pps) begin
                    // Close the old second and open the new one in the same cycle;
                    // a coincident edge belongs to the new second at count 0.
                    state_d = ST_EVAL;
                    cnt_d   = CNT_W'(1);
                    seen_d  = pps_edge;
                    cap_d   = '0;
                    if (seen_q) begin
                        err_d     = eval_err;
                        err_vld_d = 1'b1;
                        miss_d    = '0;
                        if (in_band) begin
                            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LW'(1);
                            locked_d   = (lock_cnt_d == LOCK_MAX);
                        end else begin
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                        end
                        if (auto_active) begin
                            if (eval_err > DB_POS)      sel_d = SEL_SLOW;
                            else if (eval_err < DB_NEG) sel_d = SEL_FAST;
                            else                        sel_d = SEL_MID;
                        end
                    end else begin
                        miss_d = (miss_q == MISS_MAX) ? miss_q : miss_q + MW'(1);
                        if (miss_d == MISS_MAX) begin
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                            if (auto_active) sel_d = SEL_NOM;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Returning to automatic mode forgets an earlier manual override.
        if (auto_en && !auto_en_q) manual_d = 1'b0;
        // A button press always wins over an evaluation in the same cycle.
        if (button2_pulse) begin
            manual_d = 1'b1;
            sel_d    = step_sel(sel_q);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_pps or negedge reset_pps_n) begin
        if (!reset_pps_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cap_q      <= '0;
            seen_q     <= 1'b0;
            miss_q     <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            sel_q      <= SEL_MID;
            err_q      <= '0;
            err_vld_q  <= 1'b0;
            manual_q   <= 1'b0;
            auto_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            seen_q     <= seen_d;
            miss_q     <= miss_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            err_vld_q  <= err_vld_d;
            manual_q   <= manual_d;
            auto_en_q  <= auto_en_d;
        end
    end

    assign a_incr_sel = sel_q;
    assign locked     = locked_q;
    assign phase_err  = err_q;
    assign err_valid  = err_vld_q;

endmodule

// File: tb/tb_pps_discipline_ctrl.sv
// Purpose: directed, table-driven check of pps_discipline_ctrl with a 1000-cycle second.
// Latency: each row's evaluation is sampled one cycle after the local_pps that closes it.
// Backpressure: n/a.
module tb_pps_discipline_ctrl;

    localparam int PER = 1000;
    localparam int CW  = 11;

    logic          clk_pps = 1'b0;
    logic          reset_pps_n;
    logic          pps_in;
    logic          local_pps;
    logic          button2_pulse;
    logic          auto_en;
    logic [1:0]    a_incr_sel;
    logic          locked;
    logic [CW:0]   phase_err;
    logic          err_valid;

    int            checks   = 0;
    int            failures = 0;
    logic [1:0]    msel;

    pps_discipline_ctrl #(
        .PERIOD_CYCLES (PER),
        .CNT_W         (CW),
        .DEADBAND      (4),
        .LOCK_COUNT    (4),
        .MAX_MISS      (3)
    ) dut (
        .clk_pps       (clk_pps),
        .reset_pps_n   (reset_pps_n),
        .pps_in        (pps_in),
        .local_pps     (local_pps),
        .button2_pulse (button2_pulse),
        .auto_en       (auto_en),
        .a_incr_sel    (a_incr_sel),
        .locked        (locked),
        .phase_err     (phase_err),
        .err_valid     (err_valid)
    );

    always #5 clk_pps = ~clk_pps;

    // One row per second: e1/e2 = counts at which the edge is detected (0 = none,
    // PER = coincides with the closing local_pps, i.e. count 0 of the next second).
    typedef struct {
        int         e1;
        int         e2;
        logic       au;
        int         nbtn;
        logic       vld;
        int         err;
        logic [1:0] sel;
        logic       lk;
    } vec_t;

    vec_t tbl [26];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pin high for cycles e-2..e so the synchronised edge lands at count e.
    function automatic logic hit(input int i, input int e);
        return (e > 0) && (i >= e - 2) && (i <= e);
    endfunction

    task automatic drive_cycle(input logic lp, input logic pin, input logic btn);
        local_pps     = lp;
        pps_in        = pin;
        button2_pulse = btn;
        @(posedge clk_pps);
        #1;
    endtask

    // Cycles 1..PER of a second; cycle PER carries the closing local_pps.
    task automatic do_second(input int e1, input int e2, input int nbtn, input string tag);
        int stray;
        stray = 0;
        for (int i = 1; i <= PER; i++) begin
            bit btn;
            btn = (nbtn > 0) && (i % 100 == 0) && (i / 100 <= nbtn);
            drive_cycle(i == PER, hit(i, e1) || hit(i, e2), btn);
            if (btn) begin
                msel = msel + 2'd1;
                check({tag, "_step_sel"}, a_incr_sel, msel);
            end
            if (i < PER && err_valid !== 1'b0) stray++;
        end
        check({tag, "_stray_vld"}, stray, 0);
    endtask

    task automatic check_outs(input string tag, input logic vld, input int err,
                              input logic [1:0] sel, input logic lk);
        check({tag, "_err_valid"}, err_valid, vld);
        check({tag, "_phase_err"}, $signed(phase_err), err);
        check({tag, "_sel"}, a_incr_sel, sel);
        check({tag, "_locked"}, locked, lk);
    endtask

    initial begin
        int idle_vld;

        //         e1    e2   au nbtn vld  err  sel lk
        tbl[0]  = '{10,   0,  1, 0,  1,   10,  1, 0};
        tbl[1]  = '{10,   0,  1, 0,  1,   10,  1, 0};
        tbl[2]  = '{990,  0,  1, 0,  1,  -10,  3, 0};
        tbl[3]  = '{3,    0,  1, 0,  1,    3,  2, 0};
        tbl[4]  = '{3,    0,  1, 0,  1,    3,  2, 0};
        tbl[5]  = '{3,    0,  1, 0,  1,    3,  2, 0};
        tbl[6]  = '{3,    0,  1, 0,  1,    3,  2, 1};
        tbl[7]  = '{20,   0,  1, 0,  1,   20,  1, 0};
        tbl[8]  = '{3,    0,  1, 0,  1,    3,  2, 0};
        tbl[9]  = '{3,    0,  1, 0,  1,    3,  2, 0};
        tbl[10] = '{3,    0,  1, 0,  1,    3,  2, 0};
        tbl[11] = '{3,    0,  1, 0,  1,    3,  2, 1};
        tbl[12] = '{0,    0,  1, 0,  0,    3,  2, 1};
        tbl[13] = '{0,    0,  1, 0,  0,    3,  2, 1};
        tbl[14] = '{0,    0,  1, 0,  0,    3,  0, 0};
        tbl[15] = '{10,   0,  1, 0,  1,   10,  1, 0};
        tbl[16] = '{990,  0,  1, 0,  1,  -10,  3, 0};
        tbl[17] = '{10,   0,  0, 4,  1,   10,  3, 0};
        tbl[18] = '{3,    0,  0, 0,  1,    3,  3, 0};
        tbl[19] = '{10,   0,  1, 0,  1,   10,  1, 0};
        tbl[20] = '{990,  0,  1, 1,  1,  -10,  2, 0};
        tbl[21] = '{990,  0,  0, 0,  1,  -10,  2, 0};
        tbl[22] = '{10,   0,  1, 0,  1,   10,  1, 0};
        tbl[23] = '{PER,  0,  1, 0,  0,   10,  1, 0};
        tbl[24] = '{0,    0,  1, 0,  1,    0,  2, 0};
        tbl[25] = '{7,  300,  1, 0,  1,    7,  1, 0};

        reset_pps_n   = 1'b0;
        pps_in        = 1'b0;
        local_pps     = 1'b0;
        button2_pulse = 1'b0;
        auto_en       = 1'b1;
        repeat (3) @(posedge clk_pps);
        #1;
        check_outs("in_reset", 1'b0, 0, 2'd2, 1'b0);
        reset_pps_n = 1'b1;

        // No local_pps: nothing may be evaluated.
        idle_vld = 0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            if (err_valid !== 1'b0) idle_vld++;
        end
        check("idle_err_valid_pulses", idle_vld, 0);
        check_outs("idle", 1'b0, 0, 2'd2, 1'b0);

        // First local_pps opens the first measured second.
        drive_cycle(1'b1, 1'b0, 1'b0);
        msel = 2'd2;
        for (int r = 0; r < 26; r++) begin
            string tag;
            tag = $sformatf("row%0d", r);
            auto_en = tbl[r].au;
            do_second(tbl[r].e1, tbl[r].e2, tbl[r].nbtn, tag);
            check_outs(tag, tbl[r].vld, tbl[r].err, tbl[r].sel, tbl[r].lk);
            msel = tbl[r].sel;
        end

        // Asynchronous reset right in the evaluation cycle of the last row.
        #2;
        reset_pps_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 0, 2'd2, 1'b0);
        @(posedge clk_pps);
        #1;
        reset_pps_n = 1'b1;

        // Edges while idle are ignored; the first second afterwards has no edge.
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, (i >= 2 && i <= 4), 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        msel = 2'd2;
        do_second(0, 0, 0, "post_reset_miss");
        check_outs("post_reset_miss", 1'b0, 0, 2'd2, 1'b0);
        do_second(10, 0, 0, "post_reset_eval");
        check_outs("post_reset_eval", 1'b1, 10, 2'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
